// File: rtl/matrix_serializer_pkg.sv
// Shared types and default sizing for the matrix serializer.
// Column-major ordering is selected by MATRIX_SERIALIZER_COL_MAJOR_EN (see matrix_index_counter).
package matrix_serializer_pkg;

  localparam int DEF_SIZE_A = 8;
  localparam int DEF_SIZE_B = 8;
  localparam int DEF_BITS   = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

  // An index into a dimension of n entries needs at least one bit, even for n == 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row/column walker for the serializer; row-major by default, column-major
// when MATRIX_SERIALIZER_COL_MAJOR_EN is defined.
module matrix_index_counter
  import matrix_serializer_pkg::*;
#(
  parameter int SIZE_A = DEF_SIZE_A,
  parameter int SIZE_B = DEF_SIZE_B,
  parameter int RW     = idx_width(SIZE_A),
  parameter int CW     = idx_width(SIZE_B)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          step,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  localparam logic [RW-1:0] ROW_MAX = RW'(SIZE_A - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(SIZE_B - 1);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (step) begin
`ifdef MATRIX_SERIALIZER_COL_MAJOR_EN
      if (row_q == ROW_MAX) begin
        row_d = '0;
        col_d = (col_q == COL_MAX) ? '0 : col_q + CW'(1);
      end else begin
        row_d = row_q + RW'(1);
      end
`else
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
`endif
    end
  end

  // The final index is the bottom-right corner in either order.
  assign last = (row_q == ROW_MAX) && (col_q == COL_MAX);
  assign row  = row_q;
  assign col  = col_q;

endmodule

// File: rtl/matrix_serializer.sv
// Snapshots a matrix on start and streams its elements over a valid/ready port.
// Define MATRIX_SERIALIZER_COL_MAJOR_EN for column-major order instead of row-major.
module matrix_serializer
  import matrix_serializer_pkg::*;
#(
  parameter int SIZE_A = DEF_SIZE_A,
  parameter int SIZE_B = DEF_SIZE_B,
  parameter int BITS   = DEF_BITS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic signed [BITS-1:0]          in_matrix [SIZE_A][SIZE_B],
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic signed [BITS-1:0]          out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [idx_width(SIZE_A)-1:0]    out_row,
  output logic [idx_width(SIZE_B)-1:0]    out_col,
  output logic                            out_last
);

  localparam int RW = idx_width(SIZE_A);
  localparam int CW = idx_width(SIZE_B);

  state_e state_q, state_d;

  logic signed [BITS-1:0] snap_q [SIZE_A][SIZE_B];
  logic signed [BITS-1:0] snap_d [SIZE_A][SIZE_B];

  logic          load;
  logic          step;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          last;

  matrix_index_counter #(
    .SIZE_A (SIZE_A),
    .SIZE_B (SIZE_B),
    .RW     (RW),
    .CW     (CW)
  ) u_index (
    .clk   (clk),
    .reset (reset),
    .clear (load),
    .step  (step),
    .row   (row),
    .col   (col),
    .last  (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      for (int i = 0; i < SIZE_A; i++) begin
        for (int j = 0; j < SIZE_B; j++) begin
          snap_q[i][j] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    snap_d    = snap_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          step = 1'b1;
          if (last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      snap_d = in_matrix;
    end
  end

  // Outputs are forced to zero outside STREAM so reset and idle both present a clean port.
  assign out_data = out_valid ? snap_q[row][col] : '0;
  assign out_last = out_valid & last;
  assign out_row  = row;
  assign out_col  = col;

endmodule
